audio_addr_gen: RTL
===================

# audio_addr_gen

Parametrised sample-address generator for the flash audio player: it walks the flash word address forward or backward and selects which sample inside each word to play. Play, pause, direction and restart commands come from the PS/2 keyboard strobe; pacing comes from the sample-rate `start` strobe. It sits between the keyboard interface and the flash read FSM. It generalises the fixed two-samples-per-word, wrap-only address FSM to any power-of-two packing, configurable bounds and an optional stop-at-end mode.

## Interface
- `ADDR_W`, 23, flash word-address width.
- `MIN_ADDR`, 0, first word of the sample region.
- `MAX_ADDR`, 'h7FFFF, last word of the sample region; MIN_ADDR < MAX_ADDR.
- `SUB_W`, 1, log2(samples per word); ≥1.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: sample-rate tick, one-cycle pulse.
- `keyboard_in` in 8: PS/2 scan code.
- `key_data_ready` in 1: scan code valid, asynchronous to `clk`.
- `addr` out ADDR_W: current flash word address.
- `sub_idx` out SUB_W: sample index within the word.
- `fetch` out 1: one-cycle pulse, `addr` changed and a new word must be read.
- `finish` out 1: one-cycle acknowledge of `start`.
- `playing` out 1: 1 = PLAY, 0 = PAUSE.
- `back_mode` out 1: 1 = backward.

## Operation
- Commands are scan code matched while `key_data_ready`=1: E (8'h24) = PLAY, D (8'h23) = PAUSE, F (8'h2B) = forward, B (8'h32) = backward, R (8'h2D) = RESTART. Each match is double-synchronised and rising-edge detected, so a held strobe gives exactly one command.
- States: PAUSE and PLAY. PLAY moves to PAUSE on D, or on end-of-region with the stop feature. PAUSE moves to PLAY on E. `back_mode` is an independent register set by B and cleared by F.
- On `start` in PLAY:
  - Forward: `sub_idx` increments. When wrapping from 2^SUB_W−1 to 0, `addr` increments, or goes MAX_ADDR→MIN_ADDR, and `fetch` pulses.
  - Backward: `sub_idx` decrements. When wrapping from 0 to 2^SUB_W−1, `addr` decrements, or goes MIN_ADDR→MAX_ADDR, and `fetch` pulses.
- On `start` in PAUSE: no movement, no `fetch`.
- `finish` pulses for every `start` regardless of state, so the downstream handshake never hangs.
- RESTART:
  - Forward: `addr`=MIN_ADDR, `sub_idx`=0.
  - Backward: `addr`=MAX_ADDR, `sub_idx`=2^SUB_W−1.
  - `fetch` pulses; `playing` is unchanged.
- Direction change takes effect on the next step. `sub_idx` is not altered, so the current word is not refetched.
- Simultaneous events:
  - RESTART with `start`: RESTART wins, no step, `finish` still pulses.
  - PAUSE with `start`: pause wins, no step.
  - F and B cannot coincide (single scan code).
- All address arithmetic is ADDR_W bits with explicit bound compares. No reliance on natural overflow.

## Timing
- Reset values: `addr`=MIN_ADDR, `sub_idx`=0, `fetch`=0, `finish`=0, `playing`=0, `back_mode`=0. Synchroniser flops are cleared.
- `finish`, `fetch`, `addr` and `sub_idx` update on the edge after the `start` cycle (latency 1). `fetch` is high in the same cycle the new `addr` is first visible.
- Command latency: the state change is visible after the 3rd rising edge following the first edge that samples `key_data_ready`=1 with a matching code (2 sync + 1 update).
- Reset asserted mid-operation returns all outputs to reset values immediately. Pending synchroniser state is discarded.

## Configuration
- `AUDIO_ADDR_STOP_AT_END_EN` defined: a forward `start` at `addr`=MAX_ADDR and `sub_idx`=2^SUB_W−1 (or a backward one at MIN_ADDR and 0) does not wrap. `addr`/`sub_idx` hold, `playing` clears, no `fetch`, `finish` still pulses.
- Undefined: the region wraps endlessly and `playing` changes only by command.

## Structure
- Package `audio_addr_pkg`: scan-code localparams and `typedef enum logic [2:0] {CMD_NONE, CMD_PLAY, CMD_PAUSE, CMD_FWD, CMD_BACK, CMD_RESTART} cmd_t`.
- Sub-module `key_cmd_decode`:
  - Code match, `doublesync` instance and edge detect.
  - Emits a one-cycle `cmd_t`.
- Top holds the PAUSE/PLAY register, direction, and the address/sub-index counters.

## Test plan
- Reset, SUB_W=1, press E, then 4 `start` pulses → sub_idx 1,0,1,0; addr 0,1,1,2; `fetch` on the 2nd and 4th; 4 `finish` pulses.
- PLAY forward at addr=MAX_ADDR, sub_idx=1, then `start` → addr=MIN_ADDR, sub_idx=0, `fetch`=1. With STOP_AT_END_EN instead → addr/sub hold, `playing`=0, `finish`=1.
- Press B at addr=5, sub_idx=1, then 2 `start` pulses → sub_idx 0 (addr 5), then sub_idx 1 with addr 4 and `fetch`.
- Hold `key_data_ready` for 50 cycles with code R plus a coincident `start` → exactly one RESTART (addr=MIN_ADDR, one `fetch`), no step, `finish`=1.
- Press D, then 3 `start` pulses → addr/sub unchanged, no `fetch`, 3 `finish` pulses.
- Assert `reset` mid-play for 1 cycle → all outputs at reset values; a following `start` gives only a `finish` pulse.

Source files
------------

// File: rtl/audio_addr_pkg.sv
// Shared scan codes, command and play-state types for the flash audio address generator.
// Feature macro used elsewhere: AUDIO_ADDR_STOP_AT_END_EN.
package audio_addr_pkg;

  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_F = 8'h2B;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_R = 8'h2D;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PLAY,
    CMD_PAUSE,
    CMD_FWD,
    CMD_BACK,
    CMD_RESTART
  } cmd_t;

  typedef enum logic {
    ST_PAUSE,
    ST_PLAY
  } play_st_t;

endpackage

// File: rtl/doublesync.sv
// Two-flop synchroniser for a bundle of independent level signals.
module doublesync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_cmd_decode.sv
// Matches keyboard scan codes, synchronises each match and emits a one-cycle command.
module key_cmd_decode
  import audio_addr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keyboard_in,
  input  logic       key_data_ready,
  output cmd_t       cmd_o
);

  logic [4:0] match;
  logic [4:0] sync;
  logic [4:0] prev_q;
  logic [4:0] rise;

  assign match = {5{key_data_ready}} & {
    keyboard_in == KEY_R,
    keyboard_in == KEY_B,
    keyboard_in == KEY_F,
    keyboard_in == KEY_D,
    keyboard_in == KEY_E
  };

  doublesync #(.W(5)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (match),
    .q_o   (sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= '0;
    else       prev_q <= sync;
  end

  // A held strobe stays high in sync; only its first cycle counts.
  assign rise = sync & ~prev_q;

  always_comb begin
    cmd_o = CMD_NONE;
    unique case (1'b1)
      rise[0]: cmd_o = CMD_PLAY;
      rise[1]: cmd_o = CMD_PAUSE;
      rise[2]: cmd_o = CMD_FWD;
      rise[3]: cmd_o = CMD_BACK;
      rise[4]: cmd_o = CMD_RESTART;
      default: cmd_o = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/audio_addr_gen.sv
// Flash word-address / sub-sample generator with play, pause, direction, restart.
// Optional AUDIO_ADDR_STOP_AT_END_EN stops playback at the region end instead of wrapping.
module audio_addr_gen
  import audio_addr_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MIN_ADDR = '0,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 'h7FFFF,
  parameter int                SUB_W    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        keyboard_in,
  input  logic              key_data_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [SUB_W-1:0]  sub_idx,
  output logic              fetch,
  output logic              finish,
  output logic              playing,
  output logic              back_mode
);

  localparam logic [SUB_W-1:0] SUB_MAX = {SUB_W{1'b1}};

  cmd_t              cmd;
  play_st_t          st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic              back_q, back_d;
  logic              fetch_q, fetch_d;
  logic              finish_q;
  logic              step;
  logic              hold_end;

  key_cmd_decode u_dec (
    .clk            (clk),
    .reset          (reset),
    .keyboard_in    (keyboard_in),
    .key_data_ready (key_data_ready),
    .cmd_o          (cmd)
  );

  assign step = start && (st_q == ST_PLAY) &&
                (cmd != CMD_PAUSE) && (cmd != CMD_RESTART);

`ifdef AUDIO_ADDR_STOP_AT_END_EN
  assign hold_end = back_q ?
    ((addr_q == MIN_ADDR) && (sub_q == '0)) :
    ((addr_q == MAX_ADDR) && (sub_q == SUB_MAX));
`else
  assign hold_end = 1'b0;
`endif

  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    back_d  = back_q;
    fetch_d = 1'b0;
    unique case (cmd)
      CMD_PLAY:  st_d   = ST_PLAY;
      CMD_PAUSE: st_d   = ST_PAUSE;
      CMD_FWD:   back_d = 1'b0;
      CMD_BACK:  back_d = 1'b1;
      CMD_RESTART: begin
        addr_d  = back_q ? MAX_ADDR : MIN_ADDR;
        sub_d   = back_q ? SUB_MAX : '0;
        fetch_d = 1'b1;
      end
      default: ;
    endcase
    if (step && hold_end) begin
      st_d = ST_PAUSE;
    end else if (step && !back_q) begin
      sub_d = sub_q + SUB_W'(1);
      if (sub_q == SUB_MAX) begin
        fetch_d = 1'b1;
        addr_d  = (addr_q == MAX_ADDR) ? MIN_ADDR
                                       : addr_q + ADDR_W'(1);
      end
    end else if (step) begin
      sub_d = sub_q - SUB_W'(1);
      if (sub_q == '0) begin
        fetch_d = 1'b1;
        addr_d  = (addr_q == MIN_ADDR) ? MAX_ADDR
                                       : addr_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q     <= ST_PAUSE;
      addr_q   <= MIN_ADDR;
      sub_q    <= '0;
      back_q   <= 1'b0;
      fetch_q  <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      sub_q    <= sub_d;
      back_q   <= back_d;
      fetch_q  <= fetch_d;
      finish_q <= start;
    end
  end

  assign addr      = addr_q;
  assign sub_idx   = sub_q;
  assign fetch     = fetch_q;
  assign finish    = finish_q;
  assign playing   = (st_q == ST_PLAY);
  assign back_mode = back_q;

endmodule
